// File: rtl/sorter_pkg.sv
// Shared constants for the sorted loader: default geometry and FSM state encoding.
package sorter_pkg;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_e;

endpackage

// File: rtl/sorted_loader_mem.sv
// sorted_mem: DEPTH x DW register array with two combinational read ports
// (external probe and FSM scan) and one write port shared by shift and insert.
module sorted_mem #(
  parameter int DW    = sorter_pkg::DW,
  parameter int DEPTH = sorter_pkg::DEPTH,
  parameter int AW    = sorter_pkg::AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  input  logic [AW-1:0] scan_addr,
  output logic [DW-1:0] scan_data,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data
);
  import sorter_pkg::*;

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];

  // Next array contents: at most one entry changes per cycle.
  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[wr_addr] = wr_data;
  end

  // Array storage; reset clears every entry.
  always_ff @(posedge clk) begin
    if (!rst) mem_q <= '{default: '0};
    else      mem_q <= mem_d;
  end

  assign rd_data   = mem_q[rd_addr];
  assign scan_data = mem_q[scan_addr];

endmodule

// File: rtl/sorted_loader.sv
// sorted_loader: accepts unsorted values and keeps them ascending in a register
// array by sequential insertion, one shift per cycle. busy=0 means the array is
// consistent. Optional macro SORTED_LOADER_FULL_DROP_EN lets a full array keep
// accepting values, discarding the largest entry (or the new value).
//
// state    | meaning
// ST_IDLE  | array consistent, waiting for a transfer
// ST_SCAN  | walking pointer i downward, shifting larger entries up one slot
module sorted_loader #(
  parameter int DW    = sorter_pkg::DW,
  parameter int DEPTH = sorter_pkg::DEPTH,
  parameter int AW    = sorter_pkg::AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  output logic [AW:0]   count,
  output logic          busy,
  output logic          full
);
  import sorter_pkg::*;

  state_e             state_q, state_d;
  logic [DW-1:0]      v_q, v_d;
  logic signed [AW:0] i_q, i_d;
  logic [AW:0]        count_q, count_d;
  logic               busy_q, busy_d;
`ifdef SORTED_LOADER_FULL_DROP_EN
  logic               drop_q, drop_d;
  logic               keep_q, keep_d;
`endif

  logic               xfer;
  logic               we;
  logic [AW-1:0]      wr_addr;
  logic [DW-1:0]      wr_data;
  logic [AW-1:0]      scan_addr;
  logic [DW-1:0]      scan_data;
  logic [DW-1:0]      mem_rd;

  assign full = (count_q == (AW+1)'(DEPTH));
`ifdef SORTED_LOADER_FULL_DROP_EN
  assign in_ready = !busy_q && !clr;
`else
  assign in_ready = !busy_q && !full && !clr;
`endif
  assign xfer  = in_valid && in_ready;
  assign busy  = busy_q;
  assign count = count_q;

  // In IDLE the scan port looks at the top entry so a full-array drop decision
  // can be made at accept time; in SCAN it follows the pointer.
  assign scan_addr = (state_q == ST_SCAN) ? i_q[AW-1:0] : AW'(DEPTH-1);
  // i ranges -1..DEPTH-2 while scanning, so i+1 always fits in AW bits.
  assign wr_addr   = i_q[AW-1:0] + AW'(1);
  assign rd_data   = ({1'b0, rd_addr} < count_q) ? mem_rd : '0;

  sorted_mem #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk       (clk),
    .rst       (rst),
    .rd_addr   (rd_addr),
    .rd_data   (mem_rd),
    .scan_addr (scan_addr),
    .scan_data (scan_data),
    .we        (we),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data)
  );

  // Next-state logic: clr wins over everything, then accept or scan step.
  always_comb begin
    state_d = state_q;
    v_d     = v_q;
    i_d     = i_q;
    count_d = count_q;
    busy_d  = busy_q;
    we      = 1'b0;
    wr_data = v_q;
`ifdef SORTED_LOADER_FULL_DROP_EN
    drop_d  = drop_q;
    keep_d  = keep_q;
`endif
    if (clr) begin
      state_d = ST_IDLE;
      count_d = '0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (xfer) begin
            v_d     = in_data;
            i_d     = count_q - (AW+1)'(1);
            state_d = ST_SCAN;
            busy_d  = 1'b1;
`ifdef SORTED_LOADER_FULL_DROP_EN
            drop_d  = full && (in_data >= scan_data);
            keep_d  = full;
            if (full) i_d = (AW+1)'(DEPTH-2);
`endif
          end
        end
        ST_SCAN: begin
`ifdef SORTED_LOADER_FULL_DROP_EN
          if (drop_q) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end else if (!i_q[AW] && (scan_data > v_q)) begin
            we      = 1'b1;
            wr_data = scan_data;
            i_d     = i_q - (AW+1)'(1);
          end else begin
            we      = 1'b1;
            wr_data = v_q;
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            count_d = keep_q ? count_q : count_q + (AW+1)'(1);
          end
`else
          if (!i_q[AW] && (scan_data > v_q)) begin
            we      = 1'b1;
            wr_data = scan_data;
            i_d     = i_q - (AW+1)'(1);
          end else begin
            we      = 1'b1;
            wr_data = v_q;
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            count_d = count_q + (AW+1)'(1);
          end
`endif
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // FSM, pointer, captured value and count registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      v_q     <= '0;
      i_q     <= '0;
      count_q <= '0;
      busy_q  <= 1'b0;
`ifdef SORTED_LOADER_FULL_DROP_EN
      drop_q  <= 1'b0;
      keep_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      v_q     <= v_d;
      i_q     <= i_d;
      count_q <= count_d;
      busy_q  <= busy_d;
`ifdef SORTED_LOADER_FULL_DROP_EN
      drop_q  <= drop_d;
      keep_q  <= keep_d;
`endif
    end
  end

endmodule
